// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared types and constants for the branch predictor
package branch_predictor_pkg;

  localparam int PC_W        = 12;
  localparam int DEF_ENTRIES = 16;
  localparam int DEF_IDX     = $clog2(DEF_ENTRIES);
  localparam int DEF_TAG_W   = PC_W - 2 - DEF_IDX;
  // Tag field is sized for the smallest table so any power-of-two ENTRIES fits
  localparam int TAG_W_MAX   = PC_W - 2;

  localparam logic [31:0] NOP_INSN = 32'h00000013;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_MAX-1:0] tag;
    logic [PC_W-1:0]      target;
    ctr_e                 ctr;
  } entry_t;

  function automatic logic [PC_W-1:0] pc_plus4(input logic [PC_W-1:0] pc);
    return pc + 12'd4;
  endfunction

endpackage

// File: rtl/branch_predictor_pred_table.sv
// rtl/branch_predictor_pred_table.sv - direct-mapped predictor storage, lookup and update
module pred_table
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = DEF_ENTRIES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            upd_en,
  input  logic            upd_taken,
  input  logic            upd_is_jump,
  input  logic [PC_W-1:0] upd_pc,
  input  logic [PC_W-1:0] upd_target
);

  localparam int IDX = $clog2(ENTRIES);

  entry_t tbl [ENTRIES];

  logic [IDX-1:0]       lk_idx;
  logic [IDX-1:0]       up_idx;
  logic [TAG_W_MAX-1:0] lk_tag;
  logic [TAG_W_MAX-1:0] up_tag;
  logic                 lk_hit;
  logic                 up_hit;
  entry_t               lk_ent;
  entry_t               up_ent;
  logic                 unused_pc_bits;

  // Tag is every PC bit above the index; upper field bits stay zero
  function automatic logic [TAG_W_MAX-1:0] tag_of(input logic [PC_W-1:0] pc);
    logic [TAG_W_MAX-1:0] t;
    t = pc[PC_W-1:2] >> IDX;
    return t;
  endfunction

  assign lk_idx = lookup_pc[2 +: IDX];
  assign up_idx = upd_pc[2 +: IDX];
  assign lk_tag = tag_of(lookup_pc);
  assign up_tag = tag_of(upd_pc);
  assign lk_ent = tbl[lk_idx];
  assign up_ent = tbl[up_idx];
  assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

  // Fetch lookup reads the registered table, so a same-cycle update is seen one cycle later
  always_comb begin
    lk_hit      = lk_ent.valid && (lk_ent.tag == lk_tag);
    up_hit      = up_ent.valid && (up_ent.tag == up_tag);
    pred_taken  = lk_hit && lk_ent.ctr[1];
    pred_target = lk_hit ? lk_ent.target : pc_plus4(lookup_pc);
  end

  // Allocate/train on taken, weaken on a hitting not-taken branch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
      end
    end else if (upd_en) begin
      if (upd_taken) begin
        tbl[up_idx].valid  <= 1'b1;
        tbl[up_idx].tag    <= up_tag;
        tbl[up_idx].target <= upd_target;
        if (!up_hit || upd_is_jump) begin
          tbl[up_idx].ctr <= upd_is_jump ? CTR_ST : CTR_WT;
        end else if (up_ent.ctr != CTR_ST) begin
          tbl[up_idx].ctr <= ctr_e'(up_ent.ctr + 2'd1);
        end
      end else if (!upd_is_jump && up_hit && (up_ent.ctr != CTR_SNT)) begin
        tbl[up_idx].ctr <= ctr_e'(up_ent.ctr - 2'd1);
      end
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - fetch prediction, EX-stage mispredict/redirect and statistics
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [11:0]      IF_PC,
  output logic             PRED_TAKEN,
  output logic [11:0]      PRED_TARGET,
  output logic [11:0]      NEXT_PC,
  input  logic             EX_VALID,
  input  logic             EX_IS_BRANCH,
  input  logic             EX_IS_JUMP,
  input  logic [11:0]      EX_PC,
  input  logic             EX_TAKEN,
  input  logic [11:0]      EX_TARGET,
  input  logic             EX_PRED_TAKEN,
  input  logic [11:0]      EX_PRED_TARGET,
  output logic             MISPREDICT,
  output logic [11:0]      REDIRECT_PC,
  output logic [CNT_W-1:0] BR_CNT,
  output logic [CNT_W-1:0] MISS_CNT
);

  logic resolve;

  pred_table #(.ENTRIES(ENTRIES)) u_pred_table (
    .clk         (CLK),
    .rst_n       (RSTn),
    .lookup_pc   (IF_PC),
    .pred_taken  (PRED_TAKEN),
    .pred_target (PRED_TARGET),
    .upd_en      (resolve),
    .upd_taken   (EX_TAKEN),
    .upd_is_jump (EX_IS_JUMP),
    .upd_pc      (EX_PC),
    .upd_target  (EX_TARGET)
  );

  // Resolution in EX overrides whatever fetch predicted this cycle
  always_comb begin
    resolve     = EX_VALID && (EX_IS_BRANCH || EX_IS_JUMP);
    MISPREDICT  = resolve && ((EX_TAKEN != EX_PRED_TAKEN) ||
                              (EX_TAKEN && (EX_TARGET != EX_PRED_TARGET)));
    REDIRECT_PC = EX_TAKEN ? EX_TARGET : pc_plus4(EX_PC);
    if (MISPREDICT) begin
      NEXT_PC = REDIRECT_PC;
    end else if (PRED_TAKEN) begin
      NEXT_PC = PRED_TARGET;
    end else begin
      NEXT_PC = pc_plus4(IF_PC);
    end
  end

  // Saturating resolved-instruction and misprediction counters
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      BR_CNT   <= '0;
      MISS_CNT <= '0;
    end else begin
      if (resolve && (BR_CNT != '1)) begin
        BR_CNT <= BR_CNT + CNT_W'(1);
      end
      if (MISPREDICT && (MISS_CNT != '1)) begin
        MISS_CNT <= MISS_CNT + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - randomized self-checking bench for branch_predictor
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] if_pc;
  logic        pred_taken;
  logic [11:0] pred_target;
  logic [11:0] next_pc;
  logic        ex_valid, ex_is_branch, ex_is_jump, ex_taken, ex_pred_taken;
  logic [11:0] ex_pc, ex_target, ex_pred_target;
  logic        mispredict;
  logic [11:0] redirect_pc;
  logic [31:0] br_cnt, miss_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model: table of 16 entries held as plain integers
  bit          m_valid [16];
  int          m_tag   [16];
  logic [11:0] m_tgt   [16];
  int          m_ctr   [16];
  longint      m_br, m_miss;

  // Values sampled from the DUT in the most recent cycle
  logic        s_pt, s_mis;
  logic [11:0] s_ptgt, s_next, s_redir;
  logic [31:0] s_br, s_miss;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(16), .CNT_W(32)) dut (
    .CLK(clk), .RSTn(rst_n), .IF_PC(if_pc),
    .PRED_TAKEN(pred_taken), .PRED_TARGET(pred_target), .NEXT_PC(next_pc),
    .EX_VALID(ex_valid), .EX_IS_BRANCH(ex_is_branch), .EX_IS_JUMP(ex_is_jump),
    .EX_PC(ex_pc), .EX_TAKEN(ex_taken), .EX_TARGET(ex_target),
    .EX_PRED_TAKEN(ex_pred_taken), .EX_PRED_TARGET(ex_pred_target),
    .MISPREDICT(mispredict), .REDIRECT_PC(redirect_pc),
    .BR_CNT(br_cnt), .MISS_CNT(miss_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = '0; m_ctr[i] = 1;
    end
    m_br = 0; m_miss = 0;
  endfunction

  function automatic bit m_hit(input int pc);
    return m_valid[(pc / 4) % 16] && (m_tag[(pc / 4) % 16] == pc / 64);
  endfunction

  function automatic bit m_pred(input int pc);
    return m_hit(pc) && (m_ctr[(pc / 4) % 16] >= 2);
  endfunction

  function automatic logic [11:0] m_ptgt(input int pc);
    logic [11:0] r;
    r = m_hit(pc) ? m_tgt[(pc / 4) % 16] : 12'((pc + 4) % 4096);
    return r;
  endfunction

  // One clock: drive, compare combinational + counter outputs mid-cycle, then advance model
  task automatic cycle(input logic [11:0] ipc, input bit ev, input bit ib, input bit ij,
                       input logic [11:0] epc, input bit et, input logic [11:0] etgt,
                       input bit ept, input logic [11:0] eptgt);
    bit          res, mis, e_pt;
    logic [11:0] redir, nxt, e_ptgt;
    int          k;
    if_pc = ipc; ex_valid = ev; ex_is_branch = ib; ex_is_jump = ij; ex_pc = epc;
    ex_taken = et; ex_target = etgt; ex_pred_taken = ept; ex_pred_target = eptgt;
    @(negedge clk);
    res    = ev && (ib || ij);
    mis    = res && ((et != ept) || (et && etgt != eptgt));
    redir  = et ? etgt : 12'((int'(epc) + 4) % 4096);
    e_pt   = m_pred(ipc);
    e_ptgt = m_ptgt(ipc);
    nxt    = mis ? redir : (e_pt ? e_ptgt : 12'((int'(ipc) + 4) % 4096));
    s_pt = pred_taken; s_ptgt = pred_target; s_next = next_pc; s_mis = mispredict;
    s_redir = redirect_pc; s_br = br_cnt; s_miss = miss_cnt;
    check("pred_taken", 32'(s_pt), 32'(e_pt));
    check("pred_target", 32'(s_ptgt), 32'(e_ptgt));
    check("next_pc", 32'(s_next), 32'(nxt));
    check("mispredict", 32'(s_mis), 32'(mis));
    if (res) check("redirect_pc", 32'(s_redir), 32'(redir));
    check("br_cnt", s_br, 32'(m_br));
    check("miss_cnt", s_miss, 32'(m_miss));
    @(posedge clk);
    if (res) begin
      m_br++;
      if (mis) m_miss++;
      k = (int'(epc) / 4) % 16;
      if (et) begin
        if (!m_hit(epc) || ij) m_ctr[k] = ij ? 3 : 2;
        else m_ctr[k] = (m_ctr[k] + 1 > 3) ? 3 : m_ctr[k] + 1;
        m_valid[k] = 1; m_tag[k] = int'(epc) / 64; m_tgt[k] = etgt;
      end else if (!ij && m_hit(epc)) begin
        m_ctr[k] = (m_ctr[k] - 1 < 0) ? 0 : m_ctr[k] - 1;
      end
    end
    #1;
  endtask

  task automatic idle(input logic [11:0] ipc);
    cycle(ipc, 0, 0, 0, 12'h000, 0, 12'h000, 0, 12'h000);
  endtask

  logic [11:0] pool [8] = '{12'h020, 12'h060, 12'h0A0, 12'h100, 12'h104, 12'hFFC, 12'h3F0, 12'h124};

  initial begin
    rst_n = 1'b0; if_pc = 12'h010;
    ex_valid = 0; ex_is_branch = 0; ex_is_jump = 0; ex_pc = '0; ex_taken = 0;
    ex_target = '0; ex_pred_taken = 0; ex_pred_target = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_pred_taken", 32'(pred_taken), 32'd0);
    check("rst_next_pc", 32'(next_pc), 32'h014);
    check("rst_br_cnt", br_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
    @(negedge clk); rst_n = 1'b1; @(posedge clk); #1;

    idle(12'h010);
    check("r038_next", 32'(s_next), 32'h014);

    // First taken branch at 0x020: mispredicted, redirect to 0x100
    cycle(12'h030, 1, 1, 0, 12'h020, 1, 12'h100, 0, 12'h000);
    check("r039_mis", 32'(s_mis), 32'd1);
    check("r039_next", 32'(s_next), 32'h100);
    idle(12'h020);
    check("r039_pt", 32'(s_pt), 32'd1);
    check("r039_ptgt", 32'(s_ptgt), 32'h100);
    check("r039_miss_cnt", s_miss, 32'd1);

    // Three more taken (WT->ST->ST->ST), then two not-taken (->WT->WNT)
    repeat (3) cycle(12'h020, 1, 1, 0, 12'h020, 1, 12'h100, 1, 12'h100);
    cycle(12'h020, 1, 1, 0, 12'h020, 0, 12'h100, 1, 12'h100);
    cycle(12'h020, 1, 1, 0, 12'h020, 0, 12'h100, 0, 12'h000);
    check("r040_nt2_mis", 32'(s_mis), 32'd0);
    idle(12'h020);
    check("r040_pred", 32'(s_pt), 32'd0);

    // Alias at index 8 evicts 0x020
    cycle(12'h000, 1, 1, 0, 12'h060, 1, 12'h200, 0, 12'h000);
    idle(12'h020);
    check("r041_pt", 32'(s_pt), 32'd0);
    check("r041_next", 32'(s_next), 32'h024);

    // Same-cycle lookup of 0x060 while 0x020 re-allocates index 8
    cycle(12'h060, 1, 1, 0, 12'h020, 1, 12'h300, 1, 12'h300);
    check("r042_old_pt", 32'(s_pt), 32'd1);
    check("r042_old_tgt", 32'(s_ptgt), 32'h200);
    idle(12'h020);
    check("r042_new_tgt", 32'(s_ptgt), 32'h300);

    idle(12'hFFC);
    check("r043_wrap", 32'(s_next), 32'h000);

    // Jump allocation goes straight to ST
    cycle(12'h000, 1, 0, 1, 12'h104, 1, 12'h040, 0, 12'h000);
    idle(12'h104);
    check("jump_pt", 32'(s_pt), 32'd1);

    // Asynchronous reset mid-cycle clears state before the next edge
    if_pc = 12'h020;
    #2 rst_n = 1'b0;
    #1;
    check("arst_pt", 32'(pred_taken), 32'd0);
    check("arst_next", 32'(next_pc), 32'h024);
    check("arst_br_cnt", br_cnt, 32'd0);
    check("arst_miss_cnt", miss_cnt, 32'd0);
    model_reset();
    @(negedge clk); rst_n = 1'b1; @(posedge clk); #1;

    // Randomized traffic over a small aliasing PC pool
    for (int n = 0; n < 400; n++) begin
      logic [11:0] ipc, epc, etgt, eptgt;
      bit ev, ib, ij, et, ept;
      int kind;
      ipc  = pool[$urandom_range(0, 7)];
      epc  = pool[$urandom_range(0, 7)];
      kind = $urandom_range(0, 3);
      ev   = ($urandom_range(0, 4) != 0);
      ib   = (kind == 1 || kind == 2);
      ij   = (kind == 3);
      et   = ij ? 1'b1 : bit'($urandom_range(0, 1));
      etgt = ($urandom_range(0, 1) != 0) ? pool[$urandom_range(0, 7)] : 12'($urandom_range(0, 1023) * 4);
      if ($urandom_range(0, 9) < 7) begin
        ept = m_pred(epc); eptgt = m_ptgt(epc);
      end else begin
        ept = bit'($urandom_range(0, 1)); eptgt = 12'($urandom_range(0, 1023) * 4);
      end
      cycle(ipc, ev, ib, ij, epc, et, etgt, ept, eptgt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ENTRIES, default 16; number of direct-mapped predictor entries (power of two).
REQ-002 Parameter CNT_W, default 32; width of the statistics counters.
REQ-003 CLK  input  1  sole clock; all state updates on posedge CLK.
REQ-004 RSTn  input  1  reset; asynchronous, active-low.
REQ-005 IF_PC  input  12  byte address of the instruction being fetched this cycle.
REQ-006 PRED_TAKEN  output  1  fetch-stage prediction for IF_PC; carried down the pipe by the core.
REQ-007 PRED_TARGET  output  12  predicted target for IF_PC; carried down the pipe by the core.
REQ-008 NEXT_PC  output  12  PC to be loaded into the fetch PC register at the next edge.
REQ-009 EX_VALID  input  1  EX stage holds a real (non-bubble) instruction.
REQ-010 EX_IS_BRANCH  input  1  EX instruction is a conditional branch.
REQ-011 EX_IS_JUMP  input  1  EX instruction is JAL or JALR.
REQ-012 EX_PC  input  12  PC of the EX instruction.
REQ-013 EX_TAKEN  input  1  resolved direction (1 for jumps).
REQ-014 EX_TARGET  input  12  resolved target address.
REQ-015 EX_PRED_TAKEN  input  1  prediction issued for the EX instruction.
REQ-016 EX_PRED_TARGET  input  12  predicted target issued for the EX instruction.
REQ-017 MISPREDICT  output  1  flush request for the IF/ID and ID/EX registers.
REQ-018 REDIRECT_PC  output  12  correct next PC after the EX instruction.
REQ-019 BR_CNT  output  CNT_W  resolved control-flow instructions counted.
REQ-020 MISS_CNT  output  CNT_W  mispredictions counted.

Function
REQ-021 Index = IF_PC[2+IDX-1:2], with IDX = log2(ENTRIES); tag = the remaining upper PC bits. Each entry holds: valid, tag, 12-bit target and a 2-bit counter (SNT=00, WNT=01, WT=10, ST=11).
REQ-022 Lookup is combinational: hit = valid && tag match. PRED_TAKEN = hit && counter[1]. PRED_TARGET = the entry target on a hit, else IF_PC+4.
REQ-023 All PC+4 arithmetic is 12-bit modulo: 0xFFC+4 = 0x000.
REQ-024 resolve = EX_VALID && (EX_IS_BRANCH || EX_IS_JUMP).
REQ-025 MISPREDICT = resolve && (EX_TAKEN != EX_PRED_TAKEN || (EX_TAKEN && EX_TARGET != EX_PRED_TARGET)).
REQ-026 REDIRECT_PC = EX_TAKEN ? EX_TARGET : EX_PC+4.
REQ-027 NEXT_PC = MISPREDICT ? REDIRECT_PC : (PRED_TAKEN ? PRED_TARGET : IF_PC+4). Mispredict has priority over the fetch prediction.
REQ-028 Update on a resolved, taken instruction, with the entry at EX_PC:
- Set valid, tag and target.
- On a tag miss, or on any jump, the counter becomes WT for a branch and ST for a jump.
- On a tag hit for a branch, the counter increments and saturates at ST.
REQ-029 Update on a resolved, not-taken branch: on a hit, the counter decrements and saturates at SNT; on a miss, no allocation and no change.
REQ-030 No table change when resolve=0.
REQ-031 When lookup and update target the same entry in one cycle, the lookup returns the pre-update contents; the new contents are visible from the next cycle.
REQ-032 BR_CNT increments by 1 per cycle with resolve=1. MISS_CNT increments by 1 per cycle with MISPREDICT=1. Both saturate at all-ones.

Reset
REQ-033 While RSTn=0, all entries are invalid, all counters are WNT, and BR_CNT = MISS_CNT = 0, applied asynchronously.
REQ-034 Combinational outputs during and after reset follow REQ-022..027 with empty tables: PRED_TAKEN=0 and NEXT_PC=IF_PC+4 when no resolve is pending.
REQ-035 Reset mid-operation discards all learned state; the first edge after release performs normal updates.

Structure
REQ-036 Shared package holds: the counter-state encodings, ENTRIES/IDX/TAG width constants, the entry record typedef, and the NOP encoding 32'h00000013 used by the flush logic.
REQ-037 A single sub-module, pred_table, holds entry storage, lookup and update. branch_predictor contains the mispredict, redirect, NEXT_PC and statistics logic.

Verification
REQ-038 After reset, IF_PC=0x010 -> PRED_TAKEN=0, NEXT_PC=0x014, BR_CNT=0.
REQ-039 Taken branch: EX_PC=0x020, EX_TARGET=0x100, EX_PRED_TAKEN=0 -> MISPREDICT=1, REDIRECT_PC=0x100, NEXT_PC=0x100. On the next cycle, IF_PC=0x020 -> PRED_TAKEN=1, PRED_TARGET=0x100, and MISS_CNT=1.
REQ-040 Saturation: the same branch taken 4 times, then not-taken twice -> counter walks WT->ST->ST->ST->WT->WNT. The prediction at 0x020 becomes 0, and the second not-taken reports MISPREDICT=0 when EX_PRED_TAKEN=0.
REQ-041 Aliasing: EX_PC=0x020 and then 0x060 (same index, different tag) -> the 0x060 allocation evicts the first; IF_PC=0x020 then misses with NEXT_PC=0x024.
REQ-042 Same-cycle update and lookup of index 8 -> the lookup shows the old value; the new value appears on the following cycle.
REQ-043 IF_PC=0xFFC with no hit -> NEXT_PC=0x000. Assert RSTn=0 asynchronously mid-run -> counters and valids clear before the next CLK edge.
